riscv_divider: RTL and testbench

RISCV_DIVIDER -- requirements
Module: riscv_divider

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/divu_core.sv | 55 +++++
 rtl/riscv_divider.sv | 141 ++++++++++++++
 tb/tb_riscv_divider.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V iterative divider: widths, op encodings
// and the FSM state encoding.
package riscv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/divu_core.sv
// Unsigned radix-2 restoring divider core: one quotient bit per run cycle.
// quot_next/rem_next expose the result of the step being taken this cycle.
module divu_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            run,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot_next,
    output logic [XLEN-1:0] rem_next,
    output logic            last
);

    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;
    logic             fits;

    // The shifted remainder needs one extra bit; a set top bit of diff means
    // the trial subtraction went negative and the remainder is restored.
    always_comb begin
        rem_shift = {rem_q, quot_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        fits      = ~diff[XLEN];
        rem_next  = fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_next = {quot_q[XLEN-2:0], fits};
        last      = run && (cnt_q == CNT_W'(XLEN - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            quot_q <= dividend;
            rem_q  <= '0;
            dsr_q  <= divisor;
            cnt_q  <= '0;
        end else if (run) begin
            quot_q <= quot_next;
            rem_q  <= rem_next;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/riscv_divider.sv
// RV32M divide/remainder unit: sign handling, special cases and the
// stall/done handshake around the unsigned iterative core.
module riscv_divider
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_start,
    input  logic            in_flush,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rd,
    output logic            out_busy,
    output logic            out_stall_req,
    output logic            out_done,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    div_op_e         op_q;
    logic [4:0]      rd_q;
    logic            q_neg_q;
    logic            r_neg_q;

    div_op_e         start_op;
    logic            start_signed;
    logic            neg_a;
    logic            neg_b;
    logic            div_zero;
    logic            overflow;
    logic            start_ok;
    logic            core_load;
    logic            core_run;
    logic            core_last;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] core_quot;
    logic [XLEN-1:0] core_rem;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] final_result;

    // Special cases are resolved on the start edge and bypass the core.
    always_comb begin
        start_op       = div_op_e'(in_op);
        start_signed   = op_is_signed(start_op);
        neg_a          = start_signed & in_rs1_data[XLEN-1];
        neg_b          = start_signed & in_rs2_data[XLEN-1];
        mag_a          = neg_a ? -in_rs1_data : in_rs1_data;
        mag_b          = neg_b ? -in_rs2_data : in_rs2_data;
        div_zero       = (in_rs2_data == '0);
        overflow       = start_signed && (in_rs1_data == INT_MIN) && (in_rs2_data == '1);
        if (div_zero) begin
            special_result = op_is_rem(start_op) ? in_rs1_data : '1;
        end else begin
            special_result = op_is_rem(start_op) ? '0 : INT_MIN;
        end
        start_ok       = (state == ST_IDLE) && in_start && !in_flush;
        core_load      = start_ok && !div_zero && !overflow;
        core_run       = (state == ST_CALC) && !in_flush;
        quot_fix       = q_neg_q ? -core_quot : core_quot;
        rem_fix        = r_neg_q ? -core_rem : core_rem;
        final_result   = op_is_rem(op_q) ? rem_fix : quot_fix;
    end

    divu_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .run       (core_run),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quot_next (core_quot),
        .rem_next  (core_rem),
        .last      (core_last)
    );

    assign out_busy      = (state != ST_IDLE);
    assign out_stall_req = !rst && (start_ok || (state == ST_CALC));

    // out_done and the result register are set on the edge entering DONE,
    // so the corrected value is already visible during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_DIV;
            rd_q       <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_done   <= 1'b0;
        end else begin
            out_done <= 1'b0;
            if (in_flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_start) begin
                            op_q    <= start_op;
                            rd_q    <= in_rd;
                            q_neg_q <= neg_a ^ neg_b;
                            r_neg_q <= neg_a;
                            if (div_zero || overflow) begin
                                out_result <= special_result;
                                out_rd     <= in_rd;
                                out_done   <= 1'b1;
                                state      <= ST_DONE;
                            end else begin
                                state <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        if (core_last) begin
                            out_result <= final_result;
                            out_rd     <= rd_q;
                            out_done   <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_divider.sv
// Self-checking bench for riscv_divider: vector table plus scoreboard,
// followed by flush, ignored-start and mid-operation reset sequences.
module tb_riscv_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int         LAT_N   = 33;
    localparam int         LAT_S   = 1;

    logic        clk;
    logic        rst;
    logic        in_start;
    logic        in_flush;
    logic [1:0]  in_op;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [4:0]  in_rd;
    logic        out_busy;
    logic        out_stall_req;
    logic        out_done;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          latency;
        int          start_cyc;
    } exp_t;

    vec_t        vecs[17];
    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_res;

    riscv_divider #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_start      (in_start),
        .in_flush      (in_flush),
        .in_op         (in_op),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_rd         (in_rd),
        .out_busy      (out_busy),
        .out_stall_req (out_stall_req),
        .out_done      (out_done),
        .out_result    (out_result),
        .out_rd        (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] exp_res, input int lat);
        exp_t e;
        @(negedge clk);
        in_op       = op;
        in_rs1_data = a;
        in_rs2_data = b;
        in_rd       = rd;
        in_start    = 1'b1;
        #1;
        check("stall_on_start", {31'b0, out_stall_req}, 32'd1);
        e.result    = exp_res;
        e.rd        = rd;
        e.latency   = lat;
        e.start_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        bit   found;
        bit   stall_ok;
        found    = 1'b0;
        stall_ok = 1'b1;
        for (int k = 0; k < 60 && !found; k++) begin
            if (k > 0) @(negedge clk);
            if (out_done) found = 1'b1;
            else if (!out_stall_req) stall_ok = 1'b0;
        end
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s scoreboard: no expected entry queued", name);
            return;
        end
        e = sb.pop_front();
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s timeout: out_done never seen, required after %0d cycles", name, e.latency);
            return;
        end
        check({name, "_result"}, out_result, e.result);
        check({name, "_rd"}, {27'b0, out_rd}, {27'b0, e.rd});
        check({name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.latency));
        check({name, "_stall_at_done"}, {31'b0, out_stall_req}, 32'd0);
        check({name, "_stall_in_calc"}, {31'b0, stall_ok}, 32'd1);
        last_res = e.result;
        @(negedge clk);
        check({name, "_done_pulse"}, {31'b0, out_done}, 32'd0);
        check({name, "_hold"}, out_result, e.result);
        check({name, "_idle"}, {31'b0, out_busy}, 32'd0);
    endtask

    task automatic watchNoDone(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (out_done) seen = 1'b1;
        end
        check({name, "_no_done"}, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         LAT_N};
        vecs[1]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   LAT_N};
        vecs[2]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   LAT_N};
        vecs[3]  = '{OP_REMU, 32'd7,          32'hFFFFFFFF,   32'd7,          LAT_N};
        vecs[4]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   LAT_S};
        vecs[5]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          LAT_S};
        vecs[6]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LAT_S};
        vecs[7]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          LAT_S};
        vecs[8]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   LAT_N};
        vecs[9]  = '{OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          LAT_N};
        vecs[10] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   LAT_N};
        vecs[11] = '{OP_REMU, 32'hFFFFFFFF,   32'h10,         32'hF,          LAT_N};
        vecs[12] = '{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         LAT_N};
        vecs[13] = '{OP_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   LAT_N};
        vecs[14] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          LAT_N};
        vecs[15] = '{OP_DIV,  32'd0,          32'd0,          32'hFFFFFFFF,   LAT_S};
        vecs[16] = '{OP_DIV,  32'h80000000,   32'd0,          32'hFFFFFFFF,   LAT_S};

        rst         = 1'b1;
        in_start    = 1'b1;
        in_flush    = 1'b0;
        in_op       = OP_DIVU;
        in_rs1_data = 32'd100;
        in_rs2_data = 32'd7;
        in_rd       = 5'd3;
        last_res    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, out_busy}, 32'd0);
        check("reset_done", {31'b0, out_done}, 32'd0);
        check("reset_stall", {31'b0, out_stall_req}, 32'd0);
        check("reset_result", out_result, 32'd0);
        check("reset_rd", {27'b0, out_rd}, 32'd0);
        in_start = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat);
            checkOutput($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i < 3) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'h1);
            if (i % 2 == 0) applyStimulus(OP_DIVU, a, b, 5'd20, a / b, LAT_N);
            else            applyStimulus(OP_REMU, a, b, 5'd21, a % b, LAT_N);
            checkOutput($sformatf("rand%0d", i));
        end

        // Flush at CALC cycle 10 aborts silently; a following op runs normally.
        @(negedge clk);
        in_op = OP_DIVU; in_rs1_data = 32'd100; in_rs2_data = 32'd7; in_rd = 5'd7; in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        repeat (9) @(negedge clk);
        in_flush = 1'b1;
        @(negedge clk);
        in_flush = 1'b0;
        check("flush_idle", {31'b0, out_busy}, 32'd0);
        check("flush_done", {31'b0, out_done}, 32'd0);
        watchNoDone("flush", 30);
        check("flush_hold", out_result, last_res);
        applyStimulus(OP_DIVU, 32'd9, 32'd3, 5'd9, 32'd3, LAT_N);
        checkOutput("after_flush");

        // Flush wins over a simultaneous start.
        @(negedge clk);
        in_start = 1'b1; in_flush = 1'b1; in_op = OP_DIVU; in_rs1_data = 32'd50; in_rs2_data = 32'd5;
        #1;
        check("flush_start_stall", {31'b0, out_stall_req}, 32'd0);
        @(negedge clk);
        in_start = 1'b0; in_flush = 1'b0;
        check("flush_start_busy", {31'b0, out_busy}, 32'd0);

        // A second start during CALC must not disturb the running op.
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, LAT_N);
        repeat (4) @(negedge clk);
        in_op = OP_REMU; in_rs1_data = 32'd50; in_rs2_data = 32'd0; in_rd = 5'd12; in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        checkOutput("ignored_start");
        watchNoDone("ignored_start", 5);

        // Reset in the middle of CALC discards the op.
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, LAT_N);
        void'(sb.pop_back());
        repeat (9) @(negedge clk);
        rst      = 1'b1;
        in_start = 1'b1;
        #1;
        check("midrst_busy", {31'b0, out_busy}, 32'd0);
        check("midrst_done", {31'b0, out_done}, 32'd0);
        check("midrst_result", out_result, 32'd0);
        check("midrst_rd", {27'b0, out_rd}, 32'd0);
        check("midrst_stall", {31'b0, out_stall_req}, 32'd0);
        repeat (2) @(negedge clk);
        in_start = 1'b0;
        rst      = 1'b0;
        watchNoDone("midrst", 40);
        applyStimulus(OP_DIVU, 32'd9, 32'd3, 5'd14, 32'd3, LAT_N);
        checkOutput("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
